// File: rtl/pov_pkg.sv
// Shared constants and divider state type for the POV display timing slice.
package pov_pkg;

    localparam int unsigned PERIOD_W       = 32;
    localparam int unsigned NUM_COLUMNS    = 100;
    localparam int unsigned COL_W          = $clog2(NUM_COLUMNS);
    localparam int unsigned DEFAULT_PERIOD = 3_640_000;

    typedef enum logic [1:0] {IDLE, DIV, LOAD} div_state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider by a constant: one quotient bit per cycle, done pulses in LOAD.
module seq_divider import pov_pkg::*; #(
    parameter int unsigned WIDTH   = PERIOD_W,
    parameter int unsigned DIVISOR = NUM_COLUMNS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    output logic [WIDTH-1:0] quotient,
    output logic             done
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH:0]   DIV_WIDE   = (WIDTH+1)'(DIVISOR);
    localparam logic [WIDTH-1:0] DIV_NARROW = WIDTH'(DIVISOR);

    div_state_t       state, nextState;
    logic [CNT_W-1:0] bitCnt;
    logic [WIDTH-1:0] rem, quo;
    logic [WIDTH:0]   shifted;
    logic             fits;

    // Partial remainder is always below the divisor, so the shifted value fits WIDTH+1 bits.
    assign shifted  = {rem, quo[WIDTH-1]};
    assign fits     = shifted >= DIV_WIDE;
    assign quotient = quo;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = DIV;
            DIV:     if (bitCnt == CNT_W'(WIDTH - 1)) nextState = LOAD;
            LOAD:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        done = (state == LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bitCnt <= '0;
            rem    <= '0;
            quo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bitCnt <= '0;
                        rem    <= '0;
                        quo    <= dividend;
                    end
                end
                DIV: begin
                    rem    <= fits ? (shifted[WIDTH-1:0] - DIV_NARROW) : shifted[WIDTH-1:0];
                    quo    <= {quo[WIDTH-2:0], fits};
                    bitCnt <= bitCnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rotation_timer.sv
// Measures rotor period from the hall sensor and generates per-column strobes and index.
module rotation_timer #(
    parameter int unsigned PERIOD_W       = pov_pkg::PERIOD_W,
    parameter int unsigned NUM_COLUMNS    = pov_pkg::NUM_COLUMNS,
    parameter int unsigned MIN_PERIOD     = 500_000,
    parameter int unsigned MAX_PERIOD     = 100_000_000,
    parameter int unsigned DEFAULT_PERIOD = pov_pkg::DEFAULT_PERIOD
) (
    input  logic                           clk,
    input  logic                           RESET,
    input  logic                           hallSensor,
    output logic [PERIOD_W-1:0]            rotation_period,
    output logic [PERIOD_W-1:0]            column_period,
    output logic                           col_tick,
    output logic [$clog2(NUM_COLUMNS)-1:0] col_index,
    output logic                           frame_start,
    output logic                           period_valid,
    output logic                           stalled
);

    localparam int unsigned COL_W = $clog2(NUM_COLUMNS);
    localparam logic [PERIOD_W-1:0] MIN_CNT  = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] MAX_CNT  = PERIOD_W'(MAX_PERIOD);
    localparam logic [PERIOD_W-1:0] RST_ROT  = PERIOD_W'(DEFAULT_PERIOD);
    localparam logic [PERIOD_W-1:0] RST_COL  = PERIOD_W'(DEFAULT_PERIOD / NUM_COLUMNS);
    localparam logic [COL_W-1:0]    LAST_COL = COL_W'(NUM_COLUMNS - 1);

    // The divider must be idle again before the next acceptable edge can arrive.
    if (MIN_PERIOD <= PERIOD_W + 2) begin : gMinPeriodCheck
        $error("MIN_PERIOD must exceed PERIOD_W+2");
    end

    logic                hallSync1, hallSync2, hallPrev, hallEdge;
    logic                armed, accept, stallHit, divDone, lastCol, colEnd;
    logic [PERIOD_W-1:0] cnt, sample, colCnt, colLen, quotient;

    assign accept   = hallEdge && !(armed && cnt < MIN_CNT);
    assign stallHit = armed && (cnt == MAX_CNT) && !accept;
    assign lastCol  = (col_index == LAST_COL);
    assign colEnd   = (colCnt == colLen - PERIOD_W'(1));

    always_ff @(posedge clk) begin
        if (RESET) begin
            hallSync1 <= 1'b0;
            hallSync2 <= 1'b0;
            hallPrev  <= 1'b0;
            hallEdge  <= 1'b0;
        end else begin
            hallSync1 <= hallSensor;
            hallSync2 <= hallSync1;
            hallPrev  <= hallSync2;
            hallEdge  <= hallPrev & ~hallSync2;
        end
    end

    seq_divider #(
        .WIDTH   (PERIOD_W),
        .DIVISOR (NUM_COLUMNS)
    ) uDivider (
        .clk      (clk),
        .rst      (RESET),
        .start    (accept && armed),
        .dividend (cnt),
        .quotient (quotient),
        .done     (divDone)
    );

    always_ff @(posedge clk) begin
        if (RESET) begin
            cnt             <= '0;
            sample          <= '0;
            armed           <= 1'b0;
            stalled         <= 1'b0;
            period_valid    <= 1'b0;
            rotation_period <= RST_ROT;
            column_period   <= RST_COL;
        end else begin
            if (accept) begin
                cnt     <= PERIOD_W'(1);
                armed   <= 1'b1;
                stalled <= 1'b0;
                if (armed) sample <= cnt;
            end else if (cnt != MAX_CNT) begin
                cnt <= cnt + PERIOD_W'(1);
            end
            if (stallHit) begin
                stalled      <= 1'b1;
                period_valid <= 1'b0;
                armed        <= 1'b0;
            end
            if (divDone) begin
                rotation_period <= sample;
                column_period   <= (quotient == '0) ? PERIOD_W'(1) : quotient;
                period_valid    <= 1'b1;
            end
        end
    end

    // colLen latches column_period only at column starts so a new period never splits a column.
    always_ff @(posedge clk) begin
        if (RESET) begin
            colCnt      <= '0;
            colLen      <= RST_COL;
            col_index   <= '0;
            col_tick    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            col_tick    <= 1'b0;
            frame_start <= 1'b0;
            if (accept) begin
                colCnt      <= '0;
                colLen      <= column_period;
                col_index   <= '0;
                col_tick    <= 1'b1;
                frame_start <= 1'b1;
            end else if (!stalled && !stallHit && !(armed && lastCol)) begin
                if (colEnd) begin
                    colCnt   <= '0;
                    colLen   <= column_period;
                    col_tick <= 1'b1;
                    if (lastCol) begin
                        col_index   <= '0;
                        frame_start <= 1'b1;
                    end else begin
                        col_index <= col_index + COL_W'(1);
                    end
                end else begin
                    colCnt <= colCnt + PERIOD_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rotation_timer.sv
// Self-checking bench for rotation_timer: timestamp-based reference model, vector table, corner sequences.
module tb_rotation_timer;

    localparam int NC   = 10;
    localparam int MINP = 100;
    localparam int MAXP = 10000;
    localparam int DEFP = 1000;

    logic        clk = 1'b0;
    logic        RESET;
    logic        hallSensor;
    logic [15:0] rotation_period, column_period;
    logic        col_tick, frame_start, period_valid, stalled;
    logic [3:0]  col_index;

    rotation_timer #(
        .PERIOD_W       (16),
        .NUM_COLUMNS    (NC),
        .MIN_PERIOD     (MINP),
        .MAX_PERIOD     (MAXP),
        .DEFAULT_PERIOD (DEFP)
    ) dut (
        .clk             (clk),
        .RESET           (RESET),
        .hallSensor      (hallSensor),
        .rotation_period (rotation_period),
        .column_period   (column_period),
        .col_tick        (col_tick),
        .col_index       (col_index),
        .frame_start     (frame_start),
        .period_valid    (period_valid),
        .stalled         (stalled)
    );

    always #5 clk = ~clk;

    typedef struct {
        int gap;
        int expRot;
        int expCol;
        bit expValid;
    } vec_t;

    vec_t vecs[12];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int riseAt = 0;
    int edgeQ[$];

    // Reference model: state expressed as timestamps of the last accepted edge and column start.
    bit mArmed, mStalled, mValid, mTick, mFrame;
    int mRot, mColP, mIdx, lastAcc, colStart, colLenCur, loadAt, loadRot, loadCol;

    int tickCnt, frameCnt, minGap, maxGap, lastTickCyc;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic modelUpdate();
        int since, s;
        bit edgeNow;
        if (RESET) begin
            mArmed = 0; mStalled = 0; mValid = 0; mTick = 0; mFrame = 0;
            mRot = DEFP; mColP = DEFP / NC; mIdx = 0;
            colStart = cyc; colLenCur = DEFP / NC; lastAcc = cyc; loadAt = -1;
            edgeQ.delete();
            return;
        end
        edgeNow = 0;
        if (edgeQ.size() > 0 && edgeQ[0] == cyc) begin
            edgeNow = 1;
            void'(edgeQ.pop_front());
        end
        mTick = 0; mFrame = 0;
        since = cyc - lastAcc;
        if (edgeNow && !(mArmed && since < MINP)) begin
            if (mArmed) begin
                s = (since > MAXP) ? MAXP : since;
                loadAt = cyc + 17; loadRot = s;
                loadCol = (s / NC < 1) ? 1 : s / NC;
            end
            mArmed = 1; mStalled = 0; lastAcc = cyc;
            colStart = cyc; colLenCur = mColP; mIdx = 0; mTick = 1; mFrame = 1;
        end else if (mArmed && since >= MAXP) begin
            mStalled = 1; mValid = 0; mArmed = 0;
        end else if (!mStalled && !(mArmed && mIdx == NC - 1) && cyc - colStart == colLenCur) begin
            mTick = 1; colStart = cyc; colLenCur = mColP;
            mIdx = (mIdx + 1) % NC;
            mFrame = (mIdx == 0);
        end
        if (cyc == loadAt) begin
            mRot = loadRot; mColP = loadCol; mValid = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        modelUpdate();
        #1;
        tests++;
        if (rotation_period !== 16'(mRot) || column_period !== 16'(mColP) || col_tick !== mTick ||
            col_index !== 4'(mIdx) || frame_start !== mFrame || period_valid !== mValid ||
            stalled !== mStalled) begin
            fails++;
            if (fails < 20)
                $display("FAIL cycle %0d: rot %0d/%0d col %0d/%0d tick %0b/%0b idx %0d/%0d frame %0b/%0b valid %0b/%0b stalled %0b/%0b (actual/required)",
                         cyc, rotation_period, mRot, column_period, mColP, col_tick, mTick,
                         col_index, mIdx, frame_start, mFrame, period_valid, mValid, stalled, mStalled);
        end
        if (col_tick === 1'b1) begin
            tickCnt++;
            if (cyc - lastTickCyc < minGap) minGap = cyc - lastTickCyc;
            if (cyc - lastTickCyc > maxGap) maxGap = cyc - lastTickCyc;
            lastTickCyc = cyc;
        end
        if (frame_start === 1'b1) frameCnt++;
        @(negedge clk);
        if (hallSensor == 1'b0 && cyc >= riseAt) hallSensor = 1'b1;
    endtask

    task automatic runTo(input int target);
        while (cyc < target) step();
    endtask

    task automatic fall();
        hallSensor = 1'b0;
        riseAt = cyc + 8;
        edgeQ.push_back(cyc + 4);
    endtask

    task automatic resetStats();
        tickCnt = 0; frameCnt = 0; minGap = 1 << 30; maxGap = 0; lastTickCyc = cyc;
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "_rot"},     int'(rotation_period), DEFP);
        check({tag, "_col"},     int'(column_period), DEFP / NC);
        check({tag, "_idx"},     int'(col_index), 0);
        check({tag, "_tick"},    int'(col_tick), 0);
        check({tag, "_frame"},   int'(frame_start), 0);
        check({tag, "_valid"},   int'(period_valid), 0);
        check({tag, "_stalled"}, int'(stalled), 0);
    endtask

    initial begin
        int r, prevFall, c, gap;

        vecs[0]  = '{50,   1000, 100, 1'b0};
        vecs[1]  = '{2000, 2000, 200, 1'b1};
        vecs[2]  = '{2005, 2005, 200, 1'b1};
        vecs[3]  = '{1234, 1234, 123, 1'b1};
        vecs[4]  = '{150,  150,  15,  1'b1};
        vecs[5]  = '{30,   150,  15,  1'b1};
        vecs[6]  = '{170,  200,  20,  1'b1};
        vecs[7]  = '{99,   200,  20,  1'b1};
        vecs[8]  = '{50,   149,  14,  1'b1};
        vecs[9]  = '{100,  100,  10,  1'b1};
        vecs[10] = '{9999, 9999, 999, 1'b1};
        vecs[11] = '{2500, 2500, 250, 1'b1};

        RESET = 1'b1;
        hallSensor = 1'b1;
        resetStats();
        repeat (3) step();
        RESET = 1'b0;
        checkResetValues("reset");

        // Free-running at the default rate with no hall activity.
        r = cyc;
        resetStats();
        runTo(r + 2000);
        check("free_ticks", tickCnt, 20);
        check("free_frames", frameCnt, 2);
        check("free_min_gap", minGap, 100);
        check("free_max_gap", maxGap, 100);
        check("free_valid", int'(period_valid), 0);

        prevFall = cyc;
        for (int i = 0; i < 12; i++) begin
            runTo(prevFall + vecs[i].gap);
            fall();
            prevFall = cyc;
            if (i == 1) begin
                runTo(prevFall + 20);
                check("load_not_before", int'(column_period), 100);
                runTo(prevFall + 21);
                check("load_exact", int'(column_period), 200);
            end
            runTo(prevFall + 25);
            check($sformatf("vec%0d_rot", i), int'(rotation_period), vecs[i].expRot);
            check($sformatf("vec%0d_col", i), int'(column_period), vecs[i].expCol);
            check($sformatf("vec%0d_valid", i), int'(period_valid), int'(vecs[i].expValid));
            check($sformatf("vec%0d_stalled", i), int'(stalled), 0);
        end

        // Stall after the last accepted edge, then re-arm and re-measure.
        runTo(prevFall + 4 + MAXP - 1);
        check("stall_not_yet", int'(stalled), 0);
        step();
        check("stall_set", int'(stalled), 1);
        check("stall_valid", int'(period_valid), 0);
        check("stall_rot_hold", int'(rotation_period), 2500);
        check("stall_col_hold", int'(column_period), 250);
        resetStats();
        runTo(cyc + 300);
        check("stall_no_ticks", tickCnt, 0);
        fall();
        prevFall = cyc;
        runTo(prevFall + 25);
        check("rearm_stalled", int'(stalled), 0);
        check("rearm_no_sample", int'(rotation_period), 2500);
        check("rearm_valid", int'(period_valid), 0);
        runTo(prevFall + 3000);
        fall();
        prevFall = cyc;
        runTo(prevFall + 25);
        check("post_stall_rot", int'(rotation_period), 3000);
        check("post_stall_col", int'(column_period), 300);
        check("post_stall_valid", int'(period_valid), 1);

        // Reset while the divider is busy.
        runTo(prevFall + 500);
        fall();
        c = cyc;
        runTo(c + 8);
        RESET = 1'b1;
        step();
        checkResetValues("divrst");
        RESET = 1'b0;
        runTo(c + 30);
        check("divrst_no_load_rot", int'(rotation_period), DEFP);
        check("divrst_no_load_valid", int'(period_valid), 0);

        // Random edge spacing, including bounce-range gaps.
        prevFall = cyc;
        for (int i = 0; i < 12; i++) begin
            gap = int'($urandom_range(20, 2500));
            runTo(prevFall + gap);
            fall();
            prevFall = cyc;
        end
        runTo(prevFall + 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
